// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and constants for the arrow scroll controller
package ddr_pkg;
    localparam int LANES_DEF = 4;
    localparam logic [9:0] OFFSCREEN_Y = '1;
    typedef enum logic [1:0] {IDLE, PLAY, DONE} scroll_state_t;
    typedef logic [LANES_DEF-1:0] lane_mask_t;
endpackage

// File: rtl/arrow_pattern_rom.sv
// arrow_pattern_rom: beat pattern table, one lane mask per step (bit i spawns on lane bit i)
module arrow_pattern_rom
    import ddr_pkg::*;
(
    input  logic [3:0] step,
    output lane_mask_t mask
);
    always_comb begin
        case (step)
            4'd0:    mask = 4'b1000;
            4'd1:    mask = 4'b0100;
            4'd2:    mask = 4'b0010;
            4'd3:    mask = 4'b0001;
            4'd4:    mask = 4'b1100;
            4'd5:    mask = 4'b0011;
            4'd6:    mask = 4'b1010;
            4'd7:    mask = 4'b0101;
            4'd8:    mask = 4'b1001;
            4'd9:    mask = 4'b0110;
            4'd10:   mask = 4'b1111;
            4'd11:   mask = 4'b0000;
            4'd12:   mask = 4'b1000;
            4'd13:   mask = 4'b0001;
            4'd14:   mask = 4'b0110;
            default: mask = 4'b1111;
        endcase
    end
endmodule

// File: rtl/arrow_scroll_ctrl.sv
// arrow_scroll_ctrl: per-lane arrow spawn/scroll scheduler with hit/miss judging and scoring.
// Optional combo tracking (combo_o, max_combo_o) is built when ARROW_SCROLL_COMBO_EN is defined.
module arrow_scroll_ctrl
    import ddr_pkg::*;
#(
    parameter int CORDW       = 10,
    parameter int LANES       = LANES_DEF,
    parameter int SPAWN_Y     = 480,
    parameter int TARGET_Y    = 40,
    parameter int HIT_WIN     = 8,
    parameter int SPEED       = 2,
    parameter int BEAT_FRAMES = 30,
    parameter int PATTERN_LEN = 16,
    parameter int SCOREW      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   frame_start_i,
    input  logic [LANES-1:0]       btn_i,
    output logic [CORDW*LANES-1:0] arrow_y_o,
    output logic [LANES-1:0]       arrow_valid_o,
    output logic [LANES-1:0]       hit_o,
    output logic [LANES-1:0]       miss_o,
    output logic [SCOREW-1:0]      score_o,
    output logic [SCOREW-1:0]      miss_cnt_o,
`ifdef ARROW_SCROLL_COMBO_EN
    output logic [SCOREW-1:0]      combo_o,
    output logic [SCOREW-1:0]      max_combo_o,
`endif
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int BW = $clog2(BEAT_FRAMES);
    localparam int SW = $clog2(PATTERN_LEN + 1);
    localparam logic [CORDW-1:0] OFF    = '1;
    localparam logic [CORDW-1:0] SPAWN  = CORDW'(SPAWN_Y);
    localparam logic [CORDW-1:0] SPD    = CORDW'(SPEED);
    localparam logic [CORDW-1:0] WIN_LO = CORDW'(TARGET_Y - HIT_WIN);
    localparam logic [CORDW-1:0] WIN_HI = CORDW'(TARGET_Y + HIT_WIN);
    localparam logic [CORDW-1:0] MISS_Y = CORDW'(TARGET_Y - HIT_WIN + SPEED);
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BEAT_FRAMES - 1);
    localparam logic [SW-1:0]    STEP_END  = SW'(PATTERN_LEN);

    scroll_state_t state, state_nx;
    logic [BW-1:0] beat_cnt;
    logic [SW-1:0] step;
    logic [LANES-1:0] live, hit, miss, spawn;
    lane_mask_t mask;
    logic play, beat, issued, restart;

    function automatic logic [SCOREW-1:0] sat_add(input logic [SCOREW-1:0] a, input logic [LANES-1:0] m);
        logic [SCOREW:0] s;
        s = {1'b0, a} + (SCOREW+1)'($countones(m));
        return s[SCOREW] ? '1 : s[SCOREW-1:0];
    endfunction

    assign play    = state == PLAY;
    assign beat    = play && frame_start_i && beat_cnt == BEAT_LAST;
    assign issued  = step == STEP_END;
    assign restart = start_i && !play;
    assign busy_o  = play;
    assign done_o  = state == DONE;
    assign arrow_valid_o = live;

    arrow_pattern_rom u_rom (.step(step[3:0]), .mask(mask));

    // Idle lanes park at OFF; a hit or miss clears before any move, and spawns only land on idle lanes
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CORDW-1:0] y;
        assign live[i]  = y != OFF;
        assign hit[i]   = play && btn_i[i] && live[i] && y >= WIN_LO && y <= WIN_HI;
        assign miss[i]  = play && frame_start_i && live[i] && !hit[i] && y < MISS_Y;
        assign spawn[i] = beat && !issued && mask[i] && !live[i];
        assign arrow_y_o[i*CORDW +: CORDW] = y;
        always_ff @(posedge clk_i or posedge rst_i)
            if (rst_i) y <= OFF;
            else if (restart || hit[i] || miss[i]) y <= OFF;
            else if (spawn[i]) y <= SPAWN;
            else if (play && frame_start_i && live[i]) y <= y - SPD;
    end

    always_comb begin
        state_nx = state;
        if (restart) state_nx = PLAY;
        else if (play && issued && live == '0) state_nx = DONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            step       <= '0;
            score_o    <= '0;
            miss_cnt_o <= '0;
            hit_o      <= '0;
            miss_o     <= '0;
        end else begin
            state  <= state_nx;
            hit_o  <= hit;
            miss_o <= miss;
            if (restart) begin
                beat_cnt   <= '0;
                step       <= '0;
                score_o    <= '0;
                miss_cnt_o <= '0;
            end else begin
                if (play && frame_start_i) beat_cnt <= beat ? '0 : beat_cnt + 1'b1;
                if (beat && !issued) step <= step + 1'b1;
                score_o    <= sat_add(score_o, hit);
                miss_cnt_o <= sat_add(miss_cnt_o, miss);
            end
        end
    end

`ifdef ARROW_SCROLL_COMBO_EN
    logic [SCOREW-1:0] combo_nx;
    assign combo_nx = |miss ? '0 : sat_add(combo_o, hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            combo_o     <= '0;
            max_combo_o <= '0;
        end else if (restart) begin
            combo_o     <= '0;
            max_combo_o <= '0;
        end else begin
            combo_o <= combo_nx;
            if (combo_nx > max_combo_o) max_combo_o <= combo_nx;
        end
    end
`endif
endmodule
